// File: rtl/core_run_sequencer.sv
// Host-side run sequencer: preloads core data memory, pulses core reset/start,
// times the run until done (or timeout) and streams the result window back out.
module core_run_sequencer #(
    parameter int unsigned PRELOAD_LEN    = 64,
    parameter logic [7:0]  RESULT_BASE    = 8'd64,
    parameter int unsigned RESULT_LEN     = 32,
    parameter int unsigned RESET_CYCLES   = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wen,
    input  logic [7:0]  mem_rdata,
    output logic        core_reset,
    output logic        core_start,
    input  logic        core_done,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        finished,
    output logic        timed_out,
    output logic [15:0] cycle_count
);

    localparam int unsigned   RW        = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RW-1:0] RST_LAST  = RW'(RESET_CYCLES - 1);
    localparam logic [7:0]    LOAD_LAST = 8'(PRELOAD_LEN - 1);
    localparam logic [7:0]    DUMP_LAST = 8'(RESULT_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RESET_CORE,
        S_START,
        S_RUN,
        S_DUMP,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    idx_q, idx_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [15:0]   cyc_q, cyc_d;
    logic [7:0]    k_q, k_d;
    logic          primed_q, primed_d;
    logic [7:0]    odata_q, odata_d;
    logic          ovalid_q, ovalid_d;
    logic [15:0]   cyc_inc;
    logic          prefetch;

    assign cyc_inc  = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
    // While a byte is presented, the next address is already driven so its
    // read data is ready the cycle after the handshake (2 cycles per byte).
    assign prefetch = ovalid_q && (k_q != DUMP_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            rcnt_q   <= '0;
            cyc_q    <= '0;
            k_q      <= '0;
            primed_q <= 1'b0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rcnt_q   <= rcnt_d;
            cyc_q    <= cyc_d;
            k_q      <= k_d;
            primed_q <= primed_d;
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rcnt_d     = rcnt_q;
        cyc_d      = cyc_q;
        k_d        = k_q;
        primed_d   = primed_q;
        odata_d    = odata_q;
        ovalid_d   = ovalid_q;
        in_ready   = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_wen    = 1'b0;
        core_reset = 1'b0;
        core_start = 1'b0;
        busy       = 1'b0;
        finished   = 1'b0;
        timed_out  = 1'b0;

        case (state_q)
            S_IDLE: begin
                core_reset = 1'b1;
                if (go) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    cyc_d   = '0;
                end
            end
            S_LOAD: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                in_ready   = 1'b1;
                mem_addr   = idx_q;
                if (in_valid) begin
                    mem_wen   = 1'b1;
                    mem_wdata = in_data;
                    idx_d     = idx_q + 8'd1;
                    if (idx_q == LOAD_LAST) begin
                        state_d = S_RESET_CORE;
                        rcnt_d  = '0;
                    end
                end
            end
            S_RESET_CORE: begin
                busy       = 1'b1;
                core_reset = 1'b1;
                if (rcnt_q == RST_LAST) begin
                    state_d = S_START;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            S_START: begin
                busy       = 1'b1;
                core_start = 1'b1;
                state_d    = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (core_done) begin
                    cyc_d    = cyc_inc;
                    state_d  = S_DUMP;
                    k_d      = '0;
                    primed_d = 1'b0;
                    ovalid_d = 1'b0;
                end else if (cyc_q == TIMEOUT_CYCLES) begin
                    state_d = S_ERROR;
                end else begin
                    cyc_d = cyc_inc;
                end
            end
            S_DUMP: begin
                busy     = 1'b1;
                mem_addr = RESULT_BASE + k_q + {7'd0, prefetch};
                if (!ovalid_q) begin
                    // First DUMP cycle only fetches; later ones capture the
                    // data addressed during the preceding cycle.
                    if (primed_q) begin
                        odata_d  = mem_rdata;
                        ovalid_d = 1'b1;
                    end else begin
                        primed_d = 1'b1;
                    end
                end else if (out_ready) begin
                    ovalid_d = 1'b0;
                    k_d      = k_q + 8'd1;
                    if (k_q == DUMP_LAST) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                finished = 1'b1;
                if (go) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    cyc_d   = '0;
                end
            end
            S_ERROR: begin
                timed_out  = 1'b1;
                core_reset = 1'b1;
                if (go) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                    cyc_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_data    = odata_q;
    assign out_valid   = ovalid_q;
    assign cycle_count = cyc_q;

endmodule

// File: tb/tb_core_run_sequencer.sv
// Directed bench: two sequencer instances (result window 64..95 and a wrapping
// 254..1 window) share stimulus, each with its own registered-read memory model.
module tb_core_run_sequencer;

    logic        clk = 1'b0;
    logic        reset, go, in_valid, core_done, out_ready;
    logic [7:0]  in_data;

    logic        a_in_ready, a_wen, a_core_reset, a_core_start, a_out_valid, a_busy, a_fin, a_to;
    logic [7:0]  a_addr, a_wdata, a_rdata, a_out_data;
    logic [15:0] a_cyc;
    logic        b_in_ready, b_wen, b_core_reset, b_core_start, b_out_valid, b_busy, b_fin, b_to;
    logic [7:0]  b_addr, b_wdata, b_rdata, b_out_data;
    logic [15:0] b_cyc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_run_sequencer #(
        .PRELOAD_LEN(4), .RESULT_BASE(8'd64), .RESULT_LEN(32),
        .RESET_CYCLES(2), .TIMEOUT_CYCLES(16'd20)
    ) u_a (
        .clk(clk), .reset(reset), .go(go), .in_data(in_data), .in_valid(in_valid),
        .in_ready(a_in_ready), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wen(a_wen),
        .mem_rdata(a_rdata), .core_reset(a_core_reset), .core_start(a_core_start),
        .core_done(core_done), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .busy(a_busy), .finished(a_fin), .timed_out(a_to),
        .cycle_count(a_cyc)
    );

    core_run_sequencer #(
        .PRELOAD_LEN(4), .RESULT_BASE(8'd254), .RESULT_LEN(4),
        .RESET_CYCLES(2), .TIMEOUT_CYCLES(16'd20)
    ) u_b (
        .clk(clk), .reset(reset), .go(go), .in_data(in_data), .in_valid(in_valid),
        .in_ready(b_in_ready), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wen(b_wen),
        .mem_rdata(b_rdata), .core_reset(b_core_reset), .core_start(b_core_start),
        .core_done(core_done), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .busy(b_busy), .finished(b_fin), .timed_out(b_to),
        .cycle_count(b_cyc)
    );

    // Unwritten locations read back as addr ^ 8'hA5.
    bit         a_wr [256];
    logic [7:0] a_store [256];
    bit         b_wr [256];
    logic [7:0] b_store [256];

    always @(posedge clk) begin
        if (a_wen) begin
            a_wr[a_addr]    <= 1'b1;
            a_store[a_addr] <= a_wdata;
        end
        a_rdata <= a_wr[a_addr] ? a_store[a_addr] : (a_addr ^ 8'hA5);
        if (b_wen) begin
            b_wr[b_addr]    <= 1'b1;
            b_store[b_addr] <= b_wdata;
        end
        b_rdata <= b_wr[b_addr] ? b_store[b_addr] : (b_addr ^ 8'hA5);
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       wen;
        logic [7:0] addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [7:0] fa(input int k);
        return 8'(64 + k) ^ 8'hA5;
    endfunction

    task automatic go_pulse();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic push4(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (a_core_start) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vec_t       vecs [7];
        logic [7:0] bexp [4];
        logic [7:0] off, stall_addr;
        bit         found, done_a, stall_done;
        bit [31:0]  a_seen;
        bit [3:0]   b_seen;
        int         ka, kb, stall_cnt, a_outside, b_outside, wen_bad, n;

        vecs[0] = '{1'b1, 8'd11, 1'b1, 8'd0};
        vecs[1] = '{1'b0, 8'd99, 1'b0, 8'd0};
        vecs[2] = '{1'b1, 8'd22, 1'b1, 8'd1};
        vecs[3] = '{1'b0, 8'd77, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 8'd0,  1'b0, 8'd0};
        vecs[5] = '{1'b1, 8'd33, 1'b1, 8'd2};
        vecs[6] = '{1'b1, 8'd44, 1'b1, 8'd3};
        bexp[0] = 8'h5B; bexp[1] = 8'h5A; bexp[2] = 8'd11; bexp[3] = 8'd22;

        reset = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = 8'd0;
        core_done = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_core_reset", 32'(a_core_reset), 1);
        chk("rst_busy", 32'(a_busy), 0);
        chk("rst_flags", 32'({a_fin, a_to, a_in_ready, a_wen, a_core_start, a_out_valid}), 0);
        chk("rst_cycle_count", 32'(a_cyc), 0);
        chk("rst_mem_addr", 32'(a_addr), 0);
        reset = 1'b0;

        // Run 1: preload with gaps, done 10 cycles after start, dump with a stall.
        go_pulse();
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].v;
            in_data  = vecs[i].d;
            #1;
            chk("load_in_ready", 32'(a_in_ready), 1);
            chk("load_wen", 32'(a_wen), 32'(vecs[i].wen));
            chk("load_core_reset", 32'(a_core_reset), 1);
            if (vecs[i].wen) begin
                chk("load_addr", 32'(a_addr), 32'(vecs[i].addr));
                chk("load_wdata", 32'(a_wdata), 32'(vecs[i].d));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("rc1_core_reset", 32'(a_core_reset), 1);
        chk("rc1_start_wen_ready", 32'({a_core_start, a_wen, a_in_ready}), 0);
        @(negedge clk);
        chk("rc2_core_reset", 32'(a_core_reset), 1);
        chk("rc2_core_start", 32'(a_core_start), 0);
        @(negedge clk);
        chk("start_core_reset", 32'(a_core_reset), 0);
        chk("start_core_start", 32'(a_core_start), 1);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 1) chk("run_core_start", 32'(a_core_start), 0);
            if (j == 10) core_done = 1'b1;
        end
        @(negedge clk);
        core_done = 1'b0;
        chk("run1_cycle_count", 32'(a_cyc), 10);
        chk("b_run1_cycle_count", 32'(b_cyc), 10);

        ka = 0; kb = 0; stall_cnt = 0; stall_done = 1'b0; stall_addr = 8'd0;
        a_seen = '0; b_seen = '0; a_outside = 0; b_outside = 0; wen_bad = 0;
        done_a = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 300 && !done_a; c++) begin
            if (c > 0) @(negedge clk);
            if (a_fin) begin
                done_a = 1'b1;
            end else begin
                if (a_busy) begin
                    off = a_addr - 8'd64;
                    if (off < 8'd32) a_seen[off[4:0]] = 1'b1; else a_outside++;
                    if (a_wen) wen_bad++;
                end
                if (b_busy) begin
                    off = b_addr - 8'd254;
                    if (off < 8'd4) b_seen[off[1:0]] = 1'b1; else b_outside++;
                end
                if (stall_cnt > 0) begin
                    chk("stall_out_valid", 32'(a_out_valid), 1);
                    chk("stall_addr", 32'(a_addr), 32'(stall_addr));
                end
                if (a_out_valid) chk("a_dump_byte", 32'(a_out_data), 32'(fa(ka)));
                if (b_out_valid) begin
                    if (kb < 4) chk("b_dump_byte", 32'(b_out_data), 32'(bexp[kb]));
                    else chk("b_extra_byte", 32'(b_out_valid), 0);
                end
                if (stall_cnt > 0) begin
                    out_ready = 1'b0;
                    stall_cnt--;
                end else if (!stall_done && a_out_valid && ka == 10) begin
                    out_ready  = 1'b0;
                    stall_cnt  = 4;
                    stall_done = 1'b1;
                    stall_addr = a_addr;
                end else begin
                    out_ready = 1'b1;
                end
                if (a_out_valid && out_ready) ka++;
                if (b_out_valid && out_ready) kb++;
            end
        end
        chk("dump_a_finished", 32'(done_a), 1);
        chk("dump_a_count", ka, 32);
        chk("dump_b_count", kb, 4);
        chk("dump_a_addr_cover", a_seen, 32'hFFFF_FFFF);
        chk("dump_a_addr_outside", a_outside, 0);
        chk("dump_b_addr_cover", 32'(b_seen), 32'hF);
        chk("dump_b_addr_outside", b_outside, 0);
        chk("dump_wen", wen_bad, 0);
        chk("fin_busy_reset", 32'({a_busy, a_core_reset}), 0);
        chk("fin_cycle_count", 32'(a_cyc), 10);
        chk("b_finished", 32'(b_fin), 1);

        // Run 2: done never rises -> timeout; a go during RUN must be ignored.
        go_pulse();
        push4(8'd1, 8'd2, 8'd3, 8'd4);
        wait_start(found);
        chk("run2_start_seen", 32'(found), 1);
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            go = (i == 5);
            if (a_to) begin
                n = i;
                break;
            end
        end
        go = 1'b0;
        chk("timeout_latency", n, 22);
        chk("timeout_flag", 32'(a_to), 1);
        chk("timeout_core_reset", 32'(a_core_reset), 1);
        chk("timeout_cycle_count", 32'(a_cyc), 20);
        chk("timeout_busy", 32'(a_busy), 0);
        go_pulse();
        chk("err_go_clears", 32'(a_to), 0);
        chk("err_go_load", 32'(a_in_ready), 1);

        // Run 3: done pulse during START ignored, then reset during byte 3 of dump.
        push4(8'd5, 8'd6, 8'd7, 8'd8);
        wait_start(found);
        chk("run3_start_seen", 32'(found), 1);
        core_done = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            @(negedge clk);
            core_done = (j == 5);
            if (j == 2) begin
                chk("start_done_ignored", 32'(a_cyc), 1);
                chk("start_done_no_valid", 32'(a_out_valid), 0);
            end
        end
        @(negedge clk);
        core_done = 1'b0;
        chk("run3_cycle_count", 32'(a_cyc), 5);
        ka = 0;
        found = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (a_out_valid) begin
                chk("run3_dump_byte", 32'(a_out_data), 32'(fa(ka)));
                if (ka == 3) begin
                    found = 1'b1;
                    reset = 1'b1;
                    break;
                end
                ka++;
            end
            @(negedge clk);
        end
        chk("run3_reached_byte3", 32'(found), 1);
        @(negedge clk);
        chk("midreset_out_valid", 32'(a_out_valid), 0);
        chk("midreset_core_reset", 32'(a_core_reset), 1);
        chk("midreset_busy", 32'(a_busy), 0);
        chk("midreset_cycle_count", 32'(a_cyc), 0);
        chk("midreset_b_idle", 32'({b_core_reset, b_busy}), 32'b10);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_idle", 32'({a_core_reset, a_busy, a_fin, a_to}), 32'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
